// File: rtl/mem_param_pkg.sv
// Shared types, limits and parameter legality check for the parametrised memory.
package mem_param_pkg;

    typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_e;

    localparam int unsigned MAX_RD_LATENCY = 4;

    function automatic bit params_ok(input int unsigned data_width,
                                     input int unsigned addr_width,
                                     input int unsigned depth,
                                     input int unsigned rd_latency);
        return (data_width >= 1) && (addr_width >= 1) && (addr_width <= 31) &&
               (depth >= 1) && (depth <= (32'd1 << addr_width)) &&
               (rd_latency >= 1) && (rd_latency <= MAX_RD_LATENCY);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: carries {valid,data} for the first RD_LATENCY-1 clocks;
// the parent's output register supplies the last clock of latency.
module mem_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned STAGES = RD_LATENCY - 1;

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_stages
            logic [STAGES-1:0]                 vld_q, vld_d;
            logic [STAGES-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

            always_comb begin
                vld_d[0] = in_valid;
                dat_d[0] = in_data;
                for (int i = 1; i < STAGES; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end

            // Only the qualifiers need a reset; data is don't-care until valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge clk) begin
                dat_q <= dat_d;
            end

            assign out_valid = vld_q[STAGES-1];
            assign out_data  = dat_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mem_param.sv
// Parametrised single-port memory with hardware clear sweep, pipelined reads,
// rd_valid qualifier and error pulse for rejected requests.
module mem_param
    import mem_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned            AW1       = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]         DEPTH_EXT = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH, RD_LATENCY)) begin : g_bad_params
            $error("mem_param: illegal parameter combination");
        end
    endgenerate

    mem_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    in_range_c;
    logic                    wr_en_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic                    rd_acc_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;
    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data;

    // Zero-extended compare folds to constant true when DEPTH fills the address space.
    assign in_range_c = {1'b0, addr} < DEPTH_EXT;
    assign rd_data_c  = in_range_c ? mem_q[addr] : '0;

    // Next state, clear sweep, request decode and output capture.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        err_d      = 1'b0;
        wr_en_c    = 1'b0;
        wr_addr_c  = addr;
        wr_data_c  = data_in;
        rd_acc_c   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = clr_cnt_q;
                wr_data_c = '0;
                err_d     = read | write;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (read || write) begin
                    if ((read && write) || clr || !in_range_c) begin
                        err_d = 1'b1;
                    end else if (write) begin
                        wr_en_c = 1'b1;
                    end else begin
                        rd_acc_c = 1'b1;
                    end
                end else if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase

        busy_d     = (state_d == ST_CLEAR);
        rd_valid_d = pipe_valid;
        data_out_d = pipe_valid ? pipe_data : data_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Single write port shared by the clear sweep and accepted writes.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc_c),
        .in_data   (rd_data_c),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_param.sv
// Scoreboard bench: two instances (32 words / latency 1, 20 words / latency 3)
// share one stimulus stream; a negedge monitor checks every output pulse.
module tb_mem_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0, write = 1'b0, clr = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] data_in = '0;

    logic [7:0] dout0, dout1;
    logic       rv0, rv1, busy0, busy1, err0, err1;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last0 = '0, last1 = '0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t rdq0[$], rdq1[$];
    int   errq0[$], errq1[$];

    mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .clr(clr), .addr(addr),
        .data_in(data_in), .data_out(dout0), .rd_valid(rv0), .busy(busy0), .err(err0)
    );

    mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(20), .RD_LATENCY(3)) u_dut20 (
        .clk(clk), .rst(rst), .read(read), .write(write), .clr(clr), .addr(addr),
        .data_in(data_in), .data_out(dout1), .rd_valid(rv1), .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // rwc = {read, write, clr}; exp_err = {dut20, dut32}; xd = expected read data.
    task automatic op(input logic [2:0] rwc, input logic [4:0] a, input logic [7:0] d,
                      input logic [1:0] exp_err, input logic [7:0] xd);
        read = rwc[2]; write = rwc[1]; clr = rwc[0]; addr = a; data_in = d;
        @(posedge clk);
        #1;
        if (exp_err[0])                 errq0.push_back(cyc);
        else if (rwc[2] && !rwc[1])     rdq0.push_back('{due: cyc, data: xd});
        if (exp_err[1])                 errq1.push_back(cyc);
        else if (rwc[2] && !rwc[1])     rdq1.push_back('{due: cyc + 2, data: xd});
        read = 1'b0; write = 1'b0; clr = 1'b0;
    endtask

    task automatic count_busy(input int exp0, input int exp1);
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy0) n0++;
            if (busy1) n1++;
            if (!busy0 && !busy1) break;
        end
        chk("busy_len_d32", 32'(n0), 32'(exp0));
        chk("busy_len_d20", 32'(n1), 32'(exp1));
    endtask

    task automatic chk_reset_state();
        chk("rst_data_out_d32", 32'(dout0), 32'h0);
        chk("rst_rd_valid_d32", 32'(rv0),   32'h0);
        chk("rst_err_d32",      32'(err0),  32'h0);
        chk("rst_busy_d32",     32'(busy0), 32'h1);
        chk("rst_data_out_d20", 32'(dout1), 32'h0);
        chk("rst_rd_valid_d20", 32'(rv1),   32'h0);
        chk("rst_err_d20",      32'(err1),  32'h0);
        chk("rst_busy_d20",     32'(busy1), 32'h1);
    endtask

    task automatic mon(input int k, input logic v, input logic [7:0] d, input logic e);
        exp_t       x;
        int         due;
        int         n_rd;
        int         n_err;
        logic [7:0] lst;
        n_rd  = (k == 0) ? rdq0.size()  : rdq1.size();
        n_err = (k == 0) ? errq0.size() : errq1.size();
        lst   = (k == 0) ? last0 : last1;
        if (v) begin
            if (n_rd == 0) begin
                chk($sformatf("unexpected_rd_valid_%0d", k), 32'(v), 32'h0);
            end else begin
                if (k == 0) x = rdq0.pop_front();
                else        x = rdq1.pop_front();
                chk($sformatf("rd_data_%0d", k),  32'(d),   32'(x.data));
                chk($sformatf("rd_cycle_%0d", k), 32'(cyc), 32'(x.due));
                if (k == 0) last0 = x.data;
                else        last1 = x.data;
            end
        end else begin
            chk($sformatf("data_out_hold_%0d", k), 32'(d), 32'(lst));
            if (n_rd > 0) begin
                x = (k == 0) ? rdq0[0] : rdq1[0];
                if (x.due <= cyc) begin
                    chk($sformatf("rd_valid_missing_%0d", k), 32'(v), 32'h1);
                    if (k == 0) void'(rdq0.pop_front());
                    else        void'(rdq1.pop_front());
                end
            end
        end
        if (e) begin
            if (n_err == 0) begin
                chk($sformatf("unexpected_err_%0d", k), 32'(e), 32'h0);
            end else begin
                if (k == 0) due = errq0.pop_front();
                else        due = errq1.pop_front();
                chk($sformatf("err_cycle_%0d", k), 32'(cyc), 32'(due));
            end
        end else if (n_err > 0) begin
            due = (k == 0) ? errq0[0] : errq1[0];
            if (due <= cyc) begin
                chk($sformatf("err_missing_%0d", k), 32'(e), 32'h1);
                if (k == 0) void'(errq0.pop_front());
                else        void'(errq1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, rv0, dout0, err0);
            mon(1, rv1, dout1, err1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and initial clear sweep.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy(32, 20);

        // Never-written word reads back as zero.
        op(3'b100, 5'd7, 8'h00, 2'b00, 8'h00);

        // Write then read on the next clock.
        op(3'b010, 5'd3, 8'hA5, 2'b00, 8'h00);
        op(3'b100, 5'd3, 8'h00, 2'b00, 8'hA5);

        // Back-to-back reads.
        op(3'b010, 5'd0, 8'h11, 2'b00, 8'h00);
        op(3'b010, 5'd1, 8'h22, 2'b00, 8'h00);
        op(3'b010, 5'd2, 8'h33, 2'b00, 8'h00);
        op(3'b100, 5'd0, 8'h00, 2'b00, 8'h11);
        op(3'b100, 5'd1, 8'h00, 2'b00, 8'h22);
        op(3'b100, 5'd2, 8'h00, 2'b00, 8'h33);

        // Simultaneous read and write is rejected; word keeps its value.
        op(3'b110, 5'd4, 8'hFF, 2'b11, 8'h00);
        op(3'b100, 5'd4, 8'h00, 2'b00, 8'h00);

        // Address 25 is legal for 32 words, out of range for 20.
        op(3'b010, 5'd25, 8'h77, 2'b10, 8'h00);
        op(3'b100, 5'd19, 8'h00, 2'b00, 8'h00);
        op(3'b100, 5'd25, 8'h00, 2'b10, 8'h77);
        op(3'b100, 5'd31, 8'h00, 2'b10, 8'h00);

        // clr together with a request: both ignored, error raised.
        op(3'b101, 5'd3, 8'h00, 2'b11, 8'h00);
        op(3'b011, 5'd3, 8'hEE, 2'b11, 8'h00);
        op(3'b100, 5'd3, 8'h00, 2'b00, 8'hA5);

        // Clear sweep with an in-flight read, a busy request and a busy clr.
        op(3'b010, 5'd10, 8'h5A, 2'b00, 8'h00);
        op(3'b100, 5'd3,  8'h00, 2'b00, 8'hA5);
        op(3'b001, 5'd0,  8'h00, 2'b00, 8'h00);
        op(3'b100, 5'd1,  8'h00, 2'b11, 8'h00);
        op(3'b001, 5'd0,  8'h00, 2'b00, 8'h00);
        count_busy(30, 18);
        op(3'b100, 5'd10, 8'h00, 2'b00, 8'h00);
        op(3'b100, 5'd3,  8'h00, 2'b00, 8'h00);

        // Reset in the middle of a sweep restarts it from zero.
        op(3'b010, 5'd10, 8'h5A, 2'b00, 8'h00);
        op(3'b100, 5'd10, 8'h00, 2'b00, 8'h5A);
        op(3'b001, 5'd0,  8'h00, 2'b00, 8'h00);
        repeat (12) @(posedge clk);
        #1;
        rst   = 1'b1;
        last0 = '0;
        last1 = '0;
        #1;
        chk_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy(32, 20);
        op(3'b100, 5'd10, 8'h00, 2'b00, 8'h00);
        op(3'b100, 5'd0,  8'h00, 2'b00, 8'h00);

        repeat (6) @(negedge clk);
        chk("rd_left_d32",  32'(rdq0.size()),  32'h0);
        chk("rd_left_d20",  32'(rdq1.size()),  32'h0);
        chk("err_left_d32", 32'(errq0.size()), 32'h0);
        chk("err_left_d20", 32'(errq1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_param.md
Name: mem_param

Overview:
- Parametrised successor of the team's 32x8 single-port memory model.
- Adds configurable width, depth and read latency, a rd_valid qualifier and an error flag for illegal or out-of-range requests.
- Adds a hardware clear sweep that zeroes the array after reset or on request, with busy asserted while it runs.
- Sits behind the memory UVM agent as the DUT, and is reused as a scratch RAM in larger blocks.

Parameters:
- DATA_WIDTH, 8: width of data_in and data_out.
- ADDR_WIDTH, 5: width of addr.
- DEPTH, 32: number of words; legal range 1 .. 2**ADDR_WIDTH.
- RD_LATENCY, 1: clocks from accepted read to rd_valid; legal range 1..4.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- read, input, 1: read request.
- write, input, 1: write request.
- clr, input, 1: start a clear sweep; sampled only in IDLE.
- addr, input, ADDR_WIDTH: word address.
- data_in, input, DATA_WIDTH: write data.
- data_out, output, DATA_WIDTH: read data; holds its last value when rd_valid=0.
- rd_valid, output, 1: one-cycle pulse qualifying data_out.
- busy, output, 1: high during CLEAR; requests are not accepted.
- err, output, 1: one-cycle pulse flagging a rejected request.

Behaviour:
- Reset, asynchronous, any cycle:
  - data_out=0, rd_valid=0, err=0, busy=1.
  - State goes to CLEAR, clear counter=0.
  - The read pipeline is flushed; in-flight reads are lost.
  - The array is not reset directly; the sweep zeroes it.
- State machine, states CLEAR and IDLE:
  - CLEAR: each clock writes 0 to memory[clr_cnt] and increments clr_cnt. On clr_cnt==DEPTH-1 the next state is IDLE.
  - The sweep takes exactly DEPTH clocks. busy is low from the first IDLE cycle.
  - IDLE: clr=1 (with no read/write) goes to CLEAR with clr_cnt=0. busy rises the next cycle.
  - Reads already in the pipeline still complete during the following CLEAR.
- Accept rules in IDLE, sampled at the rising edge:
  - write=1, read=0, addr<DEPTH: memory[addr] <= data_in. No delay is modelled; the write is visible to a read issued on the next clock.
  - read=1, write=0, addr<DEPTH: the read is accepted. data_out and rd_valid update RD_LATENCY clocks after the sampling edge.
  - Back-to-back reads: one accepted per clock; the pipeline is fully pipelined with no bubbles.
- Error conditions: err pulses one cycle after the sampling edge and no operation occurs when:
  - read=1 and write=1 at the same edge;
  - read or write with addr>=DEPTH (write dropped, no rd_valid);
  - read or write while busy=1;
  - clr=1 together with read or write (clr ignored, request ignored).
- clr while busy=1 is ignored without error; the sweep is not restarted.
- Widths: addr is compared unsigned against DEPTH. When DEPTH==2**ADDR_WIDTH, the out-of-range check is constant false.
- Reads return the last written value; words never written since the last sweep return 0.

Decomposition:
- Package mem_param_pkg:
  - typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_e;
  - localparam MAX_RD_LATENCY=4;
  - a function checking that parameters are legal, used by an elaboration-time assertion.
- Sub-module mem_rd_pipe:
  - parametrised (DATA_WIDTH, RD_LATENCY) shift register carrying {valid,data};
  - asynchronous reset of the valid bits only.
  - The top level holds the FSM, clear counter, array, accept/error decode and the pipe.

Test Plan:
1. Reset, then hold all inputs low -> busy=1 for exactly 32 clocks, then 0; a read of addr 7 returns 0 with rd_valid one clock later (RD_LATENCY=1).
2. Write 0xA5 to addr 3, read addr 3 on the next clock -> data_out=0xA5, rd_valid=1 one clock after the read. With RD_LATENCY=3, the same data arrives three clocks after the read.
3. Reads of addr 0,1,2 on consecutive clocks after writing 0x11, 0x22, 0x33 -> three consecutive rd_valid pulses carrying 0x11, 0x22, 0x33.
4. read=1 and write=1 together, addr 4, data 0xFF -> err pulses once, no rd_valid. A subsequent read of addr 4 returns its previous value.
5. DEPTH=20, write to addr 25 -> err pulses and the array is unchanged. A read of addr 19 is accepted normally.
6. After writing 0x5A to addr 10: pulse clr -> busy for 32 clocks, then read addr 10 -> 0x00. Separately, assert rst mid-sweep at clr_cnt=12 -> the sweep restarts from 0 and busy lasts 32 more clocks.
